// File: rtl/pattern_scan_ctrl.sv
// Serial 4-bit pattern scanner: walks a latched byte MSB first, one bit per clock,
// and reports matches in overlapping or non-overlapping mode.
module pattern_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [3:0] pat,
  input  logic       ovl,
  output logic       busy,
  output logic       done,
  output logic       match_pulse,
  output logic [3:0] match_cnt,
  output logic [7:0] match_mask
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] pat_q, pat_d;
  logic       ovl_q, ovl_d;
  logic [3:0] hist_q, hist_d;
  logic [2:0] fill_q, fill_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [7:0] match_mask_q, match_mask_d;
  logic       match_pulse_q, match_pulse_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic       load_s;
  logic       scan_bit_s;
  logic [3:0] hist_shift_s;
  logic [2:0] fill_inc_s;
  logic       hit_s;

  // Detector datapath: next history, saturating fill count and match decision.
  always_comb begin
    scan_bit_s   = data_q[3'd7 - idx_q];
    hist_shift_s = {hist_q[2:0], scan_bit_s};
    if (fill_q == 3'd4) begin
      fill_inc_s = 3'd4;
    end else begin
      fill_inc_s = fill_q + 3'd1;
    end
    hit_s = (state_q == ST_SCAN) && (fill_inc_s == 3'd4) && (hist_shift_s == pat_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    pat_d         = pat_q;
    ovl_d         = ovl_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    idx_d         = idx_q;
    match_cnt_d   = match_cnt_q;
    match_mask_d  = match_mask_q;
    match_pulse_d = 1'b0;
    done_d        = 1'b0;
    load_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        hist_d = hist_shift_s;
        if (hit_s) begin
          if (match_cnt_q == 4'hF) begin
            match_cnt_d = 4'hF;
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
          match_mask_d[idx_q] = 1'b1;
          match_pulse_d       = 1'b1;
          // Non-overlapping mode demands four fresh bits before the next hit.
          if (ovl_q) begin
            fill_d = fill_inc_s;
          end else begin
            fill_d = 3'd0;
          end
        end else begin
          fill_d = fill_inc_s;
        end
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        // The DONE exit edge doubles as an acceptance point so held start runs every 9 cycles.
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      state_d      = ST_SCAN;
      data_d       = data_in;
      pat_d        = pat;
      ovl_d        = ovl;
      hist_d       = 4'h0;
      fill_d       = 3'd0;
      idx_d        = 3'd0;
      match_cnt_d  = 4'd0;
      match_mask_d = 8'h00;
    end else begin
      data_d = data_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      data_q        <= 8'h00;
      pat_q         <= 4'h0;
      ovl_q         <= 1'b0;
      hist_q        <= 4'h0;
      fill_q        <= 3'd0;
      idx_q         <= 3'd0;
      match_cnt_q   <= 4'd0;
      match_mask_q  <= 8'h00;
      match_pulse_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      pat_q         <= pat_d;
      ovl_q         <= ovl_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      idx_q         <= idx_d;
      match_cnt_q   <= match_cnt_d;
      match_mask_q  <= match_mask_d;
      match_pulse_q <= match_pulse_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign match_pulse = match_pulse_q;
  assign match_cnt   = match_cnt_q;
  assign match_mask  = match_mask_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: hand-computed match masks/counts per scan,
// cycle-exact done/busy/match_pulse timing, start-while-busy, back-to-back and reset abort.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] pat;
  logic       ovl;
  logic       busy;
  logic       done;
  logic       match_pulse;
  logic [3:0] match_cnt;
  logic [7:0] match_mask;

  int vectors;
  int miscompares;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .pat         (pat),
    .ovl         (ovl),
    .busy        (busy),
    .done        (done),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .match_mask  (match_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan from start acceptance to the return to IDLE, checked every cycle.
  task automatic run_scan(input string name, input logic [7:0] d, input logic [3:0] p,
                          input logic o, input logic [7:0] exp_mask, input logic [3:0] exp_cnt,
                          input bit disturb);
    logic [7:0] acc_mask;
    logic [3:0] acc_cnt;
    logic       exp_done;
    acc_mask = 8'h00;
    acc_cnt  = 4'd0;
    data_in  = d;
    pat      = p;
    ovl      = o;
    start    = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || match_cnt !== 4'd0 || match_mask !== 8'h00 || match_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_accept: busy=%b done=%b cnt=%0d mask=%h pulse=%b, required busy=1 done=0 cnt=0 mask=00 pulse=0",
               name, busy, done, match_cnt, match_mask, match_pulse);
    end
    for (int i = 0; i < 8; i++) begin
      if (disturb) begin
        data_in = ~d;
        pat     = ~p;
        ovl     = ~o;
        start   = (i == 2 || i == 3);
      end
      tick();
      if (exp_mask[i]) begin
        acc_mask[i] = 1'b1;
        acc_cnt     = acc_cnt + 4'd1;
      end
      exp_done = (i == 7);
      vectors++;
      if (match_pulse !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL %s_pulse_bit%0d: got %b, required %b", name, i, match_pulse, exp_mask[i]);
      end
      vectors++;
      if (match_cnt !== acc_cnt || match_mask !== acc_mask) begin
        miscompares++;
        $display("FAIL %s_progress_bit%0d: cnt=%0d mask=%h, required cnt=%0d mask=%h",
                 name, i, match_cnt, match_mask, acc_cnt, acc_mask);
      end
      vectors++;
      if (busy !== 1'b1 || done !== exp_done) begin
        miscompares++;
        $display("FAIL %s_ctrl_bit%0d: busy=%b done=%b, required busy=1 done=%b", name, i, busy, done, exp_done);
      end
    end
    start = 1'b0;
    vectors++;
    if (match_cnt !== exp_cnt || match_mask !== exp_mask) begin
      miscompares++;
      $display("FAIL %s_result: cnt=%0d mask=%h, required cnt=%0d mask=%h", name, match_cnt, match_mask, exp_cnt, exp_mask);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0 || match_cnt !== exp_cnt || match_mask !== exp_mask) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b done=%b pulse=%b cnt=%0d mask=%h, required 0 0 0 cnt=%0d mask=%h",
               name, busy, done, match_pulse, match_cnt, match_mask, exp_cnt, exp_mask);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || match_cnt !== exp_cnt || match_mask !== exp_mask) begin
      miscompares++;
      $display("FAIL %s_hold: busy=%b cnt=%0d mask=%h, required busy=0 cnt=%0d mask=%h",
               name, busy, match_cnt, match_mask, exp_cnt, exp_mask);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0 || match_cnt !== 4'd0 || match_mask !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b pulse=%b cnt=%0d mask=%h, required all zero",
               busy, done, match_pulse, match_cnt, match_mask);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_overlap_aa();
    run_scan("ovl_aa", 8'hAA, 4'hA, 1'b1, 8'hA8, 4'd3, 1'b0);
  endtask

  task automatic test_nonoverlap_aa();
    run_scan("novl_aa", 8'hAA, 4'hA, 1'b0, 8'h88, 4'd2, 1'b0);
  endtask

  task automatic test_all_ones();
    run_scan("ovl_ff", 8'hFF, 4'hF, 1'b1, 8'hF8, 4'd5, 1'b0);
    run_scan("novl_ff", 8'hFF, 4'hF, 1'b0, 8'h88, 4'd2, 1'b0);
  endtask

  task automatic test_no_match();
    run_scan("zero", 8'h00, 4'h5, 1'b1, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_scan("busy_ign", 8'hAA, 4'hA, 1'b1, 8'hA8, 4'd3, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] m;
    logic       exp_pulse;
    int         ph;
    m       = 8'hA8;
    data_in = 8'hAA;
    pat     = 4'hA;
    ovl     = 1'b1;
    start   = 1'b1;
    for (int c = 0; c < 27; c++) begin
      tick();
      ph = c % 9;
      if (ph >= 1) begin
        exp_pulse = m[ph - 1];
      end else begin
        exp_pulse = 1'b0;
      end
      vectors++;
      if (done !== (ph == 8) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ctrl_c%0d: done=%b busy=%b, required done=%b busy=1", c, done, busy, (ph == 8));
      end
      vectors++;
      if (match_pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL b2b_pulse_c%0d: got %b, required %b", c, match_pulse, exp_pulse);
      end
      if (ph == 8) begin
        vectors++;
        if (match_cnt !== 4'd3 || match_mask !== 8'hA8) begin
          miscompares++;
          $display("FAIL b2b_result_c%0d: cnt=%0d mask=%h, required cnt=3 mask=a8", c, match_cnt, match_mask);
        end
      end
      if ((c + 1) % 9 == 0) begin
        data_in = 8'hAA;
        pat     = 4'hA;
        ovl     = 1'b1;
      end else begin
        data_in = 8'($urandom);
        pat     = 4'($urandom);
        ovl     = 1'($urandom);
      end
      if (c == 26) start = 1'b0;
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 4'd3 || match_mask !== 8'hA8) begin
      miscompares++;
      $display("FAIL b2b_end: busy=%b done=%b cnt=%0d mask=%h, required busy=0 done=0 cnt=3 mask=a8",
               busy, done, match_cnt, match_mask);
    end
  endtask

  task automatic test_reset_mid_scan();
    data_in = 8'hAA;
    pat     = 4'hA;
    ovl     = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (match_pulse !== 1'b1 || match_cnt !== 4'd1 || match_mask !== 8'h08 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: pulse=%b cnt=%0d mask=%h busy=%b, required 1 1 08 1", match_pulse, match_cnt, match_mask, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0 || match_cnt !== 4'd0 || match_mask !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b done=%b pulse=%b cnt=%0d mask=%h, required all zero",
               busy, done, match_pulse, match_cnt, match_mask);
    end
    run_scan("post_rst", 8'hFF, 4'hF, 1'b0, 8'h88, 4'd2, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    data_in     = 8'h00;
    pat         = 4'h0;
    ovl         = 1'b0;
    test_reset();
    test_overlap_aa();
    test_nonoverlap_aa();
    test_all_ones();
    test_no_match();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
